// File: rtl/peak_detect_nrx_core.sv
// peak_detect_nrx_core
// Streaming peak detector. It follows the largest qualified power value and
// counts the accepted samples that arrive after it. A peak is declared once
// NRX_TRIG samples pass without a larger qualified value.
// Optional build macro: PEAK_DETECT_TLAST_FLUSH_EN. When defined, a packet
// end (in_tlast) inside an open track also declares the held peak.
module peak_detect_nrx_core #(
  parameter int DATA_WIDTH = 16,
  parameter int NRX_TRIG   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic [DATA_WIDTH-1:0] pow_in,
  input  logic                  peak_stb_in,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic [DATA_WIDTH-1:0] pow_out,
  output logic [DATA_WIDTH-1:0] nrx_after_peak,
  output logic                  peak_stb_out
);

  localparam logic [DATA_WIDTH-1:0] TRIG = DATA_WIDTH'(NRX_TRIG);

  typedef enum logic [0:0] {IDLE, TRACK} state_t;

  state_t                state, n_state;
  logic [DATA_WIDTH-1:0] peak, n_peak;
  logic [DATA_WIDTH-1:0] cnt, n_cnt;
  logic                  n_stb;
  logic                  accept;

  // The sample word passes through the beat but plays no part in detection.
  logic unused_tdata;
  assign unused_tdata = ^in_tdata;

  // The output stage is a single register slice, so input is taken whenever
  // that slice is empty or is being drained this cycle.
  assign in_tready = out_tready || !out_tvalid;
  assign accept    = in_tvalid && in_tready;

  // Next-state decision for one accepted beat.
  always_comb begin
    n_state = state;
    n_peak  = peak;
    n_cnt   = cnt;
    n_stb   = 1'b0;
    case (state)
      IDLE: begin
        n_cnt = '0;
        if (peak_stb_in) begin
          n_peak  = pow_in;
          n_state = TRACK;
        end
      end
      TRACK: begin
        // Only a strictly larger qualified value restarts the count; ties
        // keep the original peak position.
        if (peak_stb_in && (pow_in > peak)) begin
          n_peak = pow_in;
          n_cnt  = '0;
        end else begin
          n_cnt = cnt + 1'b1;
        end
        // The count cannot exceed NRX_TRIG, so the increment never wraps.
        if (n_cnt == TRIG) begin
          n_stb   = 1'b1;
          n_state = IDLE;
        end else if (in_tlast) begin
          n_state = IDLE;
`ifdef PEAK_DETECT_TLAST_FLUSH_EN
          n_stb   = 1'b1;
`endif
        end
      end
      default: n_state = IDLE;
    endcase
  end

  // Tracking state advances only on accepted beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      peak  <= '0;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
      peak  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= n_state;
      peak  <= n_peak;
      cnt   <= n_cnt;
    end
  end

  // Output slice: load on accept, empty on a drain with no new beat, and
  // hold everything while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_tvalid     <= 1'b0;
      out_tlast      <= 1'b0;
      pow_out        <= '0;
      nrx_after_peak <= '0;
      peak_stb_out   <= 1'b0;
    end else if (clear) begin
      out_tvalid     <= 1'b0;
      out_tlast      <= 1'b0;
      pow_out        <= '0;
      nrx_after_peak <= '0;
      peak_stb_out   <= 1'b0;
    end else if (accept) begin
      out_tvalid     <= 1'b1;
      out_tlast      <= in_tlast;
      pow_out        <= n_peak;
      nrx_after_peak <= n_cnt;
      peak_stb_out   <= n_stb;
    end else if (out_tready) begin
      out_tvalid     <= 1'b0;
      peak_stb_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peak_detect_nrx_core.sv
// Scoreboard bench for peak_detect_nrx_core. Expected beats are computed from
// a behavioural model when stimulus is accepted and compared when drained.
module tb_peak_detect_nrx_core;
  localparam int W = 16;
  localparam int N = 16;

`ifdef PEAK_DETECT_TLAST_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, clear;
  logic         in_tvalid, in_tready, in_tlast;
  logic [W-1:0] in_tdata, pow_in;
  logic         peak_stb_in;
  logic         out_tvalid, out_tready, out_tlast;
  logic [W-1:0] pow_out, nrx_after_peak;
  logic         peak_stb_out;

  peak_detect_nrx_core #(.DATA_WIDTH(W), .NRX_TRIG(N)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .in_tdata(in_tdata), .pow_in(pow_in), .peak_stb_in(peak_stb_in),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .pow_out(pow_out), .nrx_after_peak(nrx_after_peak),
    .peak_stb_out(peak_stb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit last;
    int pow;
    int nrx;
    bit stb;
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    exp_stb = 0;
  int    obs_stb = 0;

  // model state
  bit m_track = 1'b0;
  int m_peak  = 0;
  int m_cnt   = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_track = 1'b0;
    m_peak  = 0;
    m_cnt   = 0;
    q.delete();
  endtask

  task automatic model_beat(int p, bit last);
    beat_t b;
    bit    qual;
    qual  = (p > 10000);
    b.stb = 1'b0;
    if (!m_track) begin
      m_cnt = 0;
      if (qual) begin
        m_peak  = p;
        m_track = 1'b1;
      end
    end else begin
      if (qual && p > m_peak) begin
        m_peak = p;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (m_cnt == N) begin
        b.stb   = 1'b1;
        m_track = 1'b0;
      end else if (last) begin
        b.stb   = FLUSH;
        m_track = 1'b0;
      end
    end
    b.last = last;
    b.pow  = m_peak;
    b.nrx  = m_cnt;
    if (b.stb) exp_stb++;
    q.push_back(b);
  endtask

  // One clock of stimulus: drive, check the handshake view, drain, accept.
  task automatic step(bit v, int p, bit last, bit ordy);
    beat_t e;
    bit    acc;
    @(negedge clk);
    in_tvalid   = v;
    pow_in      = p[W-1:0];
    peak_stb_in = (p > 10000);
    in_tlast    = last;
    in_tdata    = W'($urandom);
    out_tready  = ordy;
    #1;
    chk("vld", out_tvalid, q.size() != 0);
    chk("rdy", in_tready, ordy || q.size() == 0);
    acc = v && (ordy || q.size() == 0);
    if (out_tvalid && out_tready && peak_stb_out) obs_stb++;
    if (ordy && q.size() != 0) begin
      e = q.pop_front();
      chk("pow",  pow_out, e.pow);
      chk("nrx",  nrx_after_peak, e.nrx);
      chk("stb",  peak_stb_out, e.stb);
      chk("last", out_tlast, e.last);
    end
    if (acc) model_beat(p, last);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear     = 1'b1;
    in_tvalid = 1'b0;
    out_tready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    #1;
    chk("clr_vld", out_tvalid, 0);
    chk("clr_pow", pow_out, 0);
    chk("clr_nrx", nrx_after_peak, 0);
    chk("clr_stb", peak_stb_out, 0);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int sp[5];
    sp = '{0, 0, 12000, 15000, 11000};
    reset = 1'b0; clear = 1'b0;
    in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0; pow_in = '0;
    peak_stb_in = 1'b0; out_tready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_vld", out_tvalid, 0);
    chk("rst_pow", pow_out, 0);
    chk("rst_nrx", nrx_after_peak, 0);
    chk("rst_stb", peak_stb_out, 0);
    reset = 1'b1;

    // single peak, strobe 16 samples after 15000
    foreach (sp[i]) step(1'b1, sp[i], 1'b0, 1'b1);
    repeat (16) step(1'b1, 500, 1'b0, 1'b1);
    drain();

    // restart by a larger value
    step(1'b1, 15000, 1'b0, 1'b1);
    repeat (5) step(1'b1, 500, 1'b0, 1'b1);
    step(1'b1, 20000, 1'b0, 1'b1);
    repeat (18) step(1'b1, 500, 1'b0, 1'b1);
    drain();

    // equal value does not restart
    step(1'b1, 15000, 1'b0, 1'b1);
    repeat (3) step(1'b1, 500, 1'b0, 1'b1);
    step(1'b1, 15000, 1'b0, 1'b1);
    repeat (14) step(1'b1, 500, 1'b0, 1'b1);
    drain();

    // backpressure on the trigger beat
    step(1'b1, 15000, 1'b0, 1'b1);
    repeat (16) step(1'b1, 500, 1'b0, 1'b1);
    repeat (3) step(1'b1, 500, 1'b0, 1'b0);
    step(1'b1, 500, 1'b0, 1'b1);
    drain();

    // tlast mid-track at cnt=7
    step(1'b1, 15000, 1'b0, 1'b1);
    repeat (6) step(1'b1, 500, 1'b0, 1'b1);
    step(1'b1, 500, 1'b1, 1'b1);
    step(1'b1, 12000, 1'b0, 1'b1);
    drain();

    // trigger and tlast on the same beat
    step(1'b1, 15000, 1'b0, 1'b1);
    repeat (15) step(1'b1, 500, 1'b0, 1'b1);
    step(1'b1, 500, 1'b1, 1'b1);
    drain();

    // clear mid-track discards without a strobe
    step(1'b1, 30000, 1'b0, 1'b1);
    repeat (4) step(1'b1, 500, 1'b0, 1'b1);
    do_clear();
    repeat (20) step(1'b1, 500, 1'b0, 1'b1);
    drain();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int p;
      p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10001, 60000))
                                       : int'($urandom_range(0, 12000));
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0);
    end
    drain();

    chk("stb_count", obs_stb, exp_stb);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
